// File: rtl/a2card_arb_pkg.sv
//------------------------------------------------------------------------------
// Package : a2card_arb_pkg
// Purpose : Shared types for the slot-card arbiter: arbitration mode selector
//           and grant state machine encoding.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package a2card_arb_pkg;

  // Arbitration policy selected at elaboration time.
  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,  // lowest card index wins
    ARB_RR    = 1'b1   // round-robin from the rotating pointer
  } arb_mode_e;

  // Per-bus-cycle grant state.
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } grant_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_priority_encoder.sv
//------------------------------------------------------------------------------
// Module  : rr_priority_encoder
// Purpose : Finds the first asserted request at or after a start pointer,
//           wrapping from N-1 back to 0. Tying the pointer to zero gives a
//           plain lowest-index-first priority encoder.
// Ports   : i_req        N-bit request vector
//           i_ptr        start index for the search
//           o_grant_oh   one-hot winner (all-zero if no request)
//           o_grant_idx  binary winner index (0 if no request)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_priority_encoder #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant_oh,
  output logic [IW-1:0] o_grant_idx
);

  logic w_found;
  int   w_j;

  // Walk the N candidates in rotated order; the first hit is latched by
  // w_found so later candidates cannot override it.
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_j         = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_j]) begin
        w_found         = 1'b1;
        o_grant_oh[w_j] = 1'b1;
        o_grant_idx     = IW'(w_j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slot_card_arbiter.sv
//------------------------------------------------------------------------------
// Module  : slot_card_arbiter
// Purpose : Arbitrates N slot-card read responses onto the single bus
//           data-out path with the grant locked for a whole bus cycle,
//           flags/counts collisions, and aggregates masked card IRQs with
//           sticky, acknowledgeable pending bits.
// Ports   : clk_logic / system_reset_n  logic clock, sync active-low reset
//           phi1_posedge_i               start-of-bus-cycle pulse
//           rd_en_i, data_i              per-card read request and data
//           bus_data_i                   default data when nobody is granted
//           irq_n_i, irq_mask_i,         per-card IRQ (active-low), mask,
//           irq_ack_i                    write-1-to-clear pending acks
//           data_out_en_o, data_out_o    registered bus data-out path
//           grant_o, grant_idx_o         current grant (one-hot / index)
//           collision_o, collision_count_o  collision pulse / saturating count
//           irq_n_o, irq_pending_o       aggregate IRQ / sticky pending bits
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module slot_card_arbiter
  import a2card_arb_pkg::*;
#(
  parameter int        NUM_CARDS  = 4,
  parameter int        DATA_WIDTH = 8,
  parameter arb_mode_e ARB_MODE   = ARB_FIXED,
  parameter int        CNT_WIDTH  = 16
) (
  input  logic                                  clk_logic,
  input  logic                                  system_reset_n,
  input  logic                                  phi1_posedge_i,
  input  logic [NUM_CARDS-1:0]                  rd_en_i,
  input  logic [NUM_CARDS-1:0][DATA_WIDTH-1:0]  data_i,
  input  logic [DATA_WIDTH-1:0]                 bus_data_i,
  input  logic [NUM_CARDS-1:0]                  irq_n_i,
  input  logic [NUM_CARDS-1:0]                  irq_mask_i,
  input  logic [NUM_CARDS-1:0]                  irq_ack_i,
  output logic                                  data_out_en_o,
  output logic [DATA_WIDTH-1:0]                 data_out_o,
  output logic [NUM_CARDS-1:0]                  grant_o,
  output logic [$clog2(NUM_CARDS)-1:0]          grant_idx_o,
  output logic                                  collision_o,
  output logic [CNT_WIDTH-1:0]                  collision_count_o,
  output logic                                  irq_n_o,
  output logic [NUM_CARDS-1:0]                  irq_pending_o
);

  localparam int IW = $clog2(NUM_CARDS);

  grant_state_e           r_state;
  logic [IW-1:0]          r_rr_ptr;
  logic                   r_coll_seen;
  logic                   r_en;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [NUM_CARDS-1:0]   r_grant;
  logic [IW-1:0]          r_grant_idx;
  logic                   r_coll;
  logic [CNT_WIDTH-1:0]   r_coll_cnt;
  logic                   r_irq_n;
  logic [NUM_CARDS-1:0]   r_pending;

  logic [IW-1:0]          w_start;
  logic [NUM_CARDS-1:0]   w_win_oh;
  logic [IW-1:0]          w_win_idx;
  logic [IW-1:0]          w_ptr_next;
  logic                   w_any;
  logic                   w_rearb;
  logic                   w_multi;
  logic                   w_intrude;
  logic                   w_seen;
  logic                   w_coll;
  logic [NUM_CARDS-1:0]   w_irq_req;

  // Fixed priority is the round-robin search with the pointer pinned at 0.
  assign w_start = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;

  rr_priority_encoder #(
    .N  (NUM_CARDS),
    .IW (IW)
  ) u_enc (
    .i_req       (rd_en_i),
    .i_ptr       (w_start),
    .o_grant_oh  (w_win_oh),
    .o_grant_idx (w_win_idx)
  );

  assign w_any      = |rd_en_i;
  // A bus-cycle boundary releases the lock and allows same-cycle re-arbitration.
  assign w_rearb    = (r_state == ST_IDLE) || phi1_posedge_i;
  assign w_ptr_next = (w_win_idx == IW'(NUM_CARDS - 1)) ? '0 : w_win_idx + IW'(1);

  // x & (x-1) clears the lowest set bit; anything left means >= 2 requesters.
  assign w_multi   = |(rd_en_i & (rd_en_i - NUM_CARDS'(1)));
  assign w_intrude = (r_state == ST_GRANTED) && !phi1_posedge_i && |(rd_en_i & ~r_grant);
  // The one-pulse-per-bus-cycle guard is forgotten at the cycle boundary.
  assign w_seen    = r_coll_seen && !phi1_posedge_i;
  assign w_coll    = (w_multi || w_intrude) && !w_seen;

  assign w_irq_req = ~irq_n_i & irq_mask_i;

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_coll_seen <= 1'b0;
      r_en        <= 1'b0;
      r_data      <= '0;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_coll      <= 1'b0;
      r_coll_cnt  <= '0;
      r_irq_n     <= 1'b1;
      r_pending   <= '0;
    end else begin
      if (w_rearb) begin
        if (w_any) begin
          r_state     <= ST_GRANTED;
          r_grant     <= w_win_oh;
          r_grant_idx <= w_win_idx;
          r_en        <= 1'b1;
          r_data      <= data_i[w_win_idx];
          if (ARB_MODE == ARB_RR) begin
            r_rr_ptr <= w_ptr_next;
          end
        end else begin
          r_state     <= ST_IDLE;
          r_grant     <= '0;
          r_grant_idx <= '0;
          r_en        <= 1'b0;
          r_data      <= bus_data_i;
        end
      end else begin
        // Locked: keep the winner, follow its live data.
        r_data <= data_i[r_grant_idx];
      end

      r_coll      <= w_coll;
      r_coll_seen <= w_seen || w_coll;
      if (w_coll && (r_coll_cnt != '1)) begin
        r_coll_cnt <= r_coll_cnt + CNT_WIDTH'(1);
      end

      // New request wins over a simultaneous acknowledge.
      r_pending <= w_irq_req | (r_pending & ~irq_ack_i);
      r_irq_n   <= ~|w_irq_req;
    end
  end

  assign data_out_en_o     = r_en;
  assign data_out_o        = r_data;
  assign grant_o           = r_grant;
  assign grant_idx_o       = r_grant_idx;
  assign collision_o       = r_coll;
  assign collision_count_o = r_coll_cnt;
  assign irq_n_o           = r_irq_n;
  assign irq_pending_o     = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_slot_card_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_slot_card_arbiter
// Purpose : Directed self-checking bench. One fixed-priority instance
//           (16-bit counter) and one round-robin instance (2-bit counter)
//           share the same stimulus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_slot_card_arbiter;
  import a2card_arb_pkg::*;

  logic             clk_logic;
  logic             system_reset_n;
  logic             phi1_posedge_i;
  logic [3:0]       rd_en_i;
  logic [3:0][7:0]  data_i;
  logic [7:0]       bus_data_i;
  logic [3:0]       irq_n_i;
  logic [3:0]       irq_mask_i;
  logic [3:0]       irq_ack_i;

  logic             fx_en, rr_en;
  logic [7:0]       fx_data, rr_data;
  logic [3:0]       fx_grant, rr_grant;
  logic [1:0]       fx_idx, rr_idx;
  logic             fx_coll, rr_coll;
  logic [15:0]      fx_cnt;
  logic [1:0]       rr_cnt;
  logic             fx_irq_n, rr_irq_n;
  logic [3:0]       fx_pend, rr_pend;

  int n_checks = 0;
  int n_errors = 0;

  slot_card_arbiter #(
    .NUM_CARDS(4), .DATA_WIDTH(8), .ARB_MODE(ARB_FIXED), .CNT_WIDTH(16)
  ) u_dut_fx (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n),
    .phi1_posedge_i(phi1_posedge_i), .rd_en_i(rd_en_i), .data_i(data_i),
    .bus_data_i(bus_data_i), .irq_n_i(irq_n_i), .irq_mask_i(irq_mask_i),
    .irq_ack_i(irq_ack_i), .data_out_en_o(fx_en), .data_out_o(fx_data),
    .grant_o(fx_grant), .grant_idx_o(fx_idx), .collision_o(fx_coll),
    .collision_count_o(fx_cnt), .irq_n_o(fx_irq_n), .irq_pending_o(fx_pend)
  );

  slot_card_arbiter #(
    .NUM_CARDS(4), .DATA_WIDTH(8), .ARB_MODE(ARB_RR), .CNT_WIDTH(2)
  ) u_dut_rr (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n),
    .phi1_posedge_i(phi1_posedge_i), .rd_en_i(rd_en_i), .data_i(data_i),
    .bus_data_i(bus_data_i), .irq_n_i(irq_n_i), .irq_mask_i(irq_mask_i),
    .irq_ack_i(irq_ack_i), .data_out_en_o(rr_en), .data_out_o(rr_data),
    .grant_o(rr_grant), .grant_idx_o(rr_idx), .collision_o(rr_coll),
    .collision_count_o(rr_cnt), .irq_n_o(rr_irq_n), .irq_pending_o(rr_pend)
  );

  initial clk_logic = 1'b0;
  always #5 clk_logic = ~clk_logic;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk_logic);
    #1;
  endtask

  task automatic check_reset_fx(input string tag);
    check({tag, " en"},      32'(fx_en),    32'd0);
    check({tag, " data"},    32'(fx_data),  32'h00);
    check({tag, " grant"},   32'(fx_grant), 32'h0);
    check({tag, " idx"},     32'(fx_idx),   32'd0);
    check({tag, " coll"},    32'(fx_coll),  32'd0);
    check({tag, " cnt"},     32'(fx_cnt),   32'd0);
    check({tag, " irq_n"},   32'(fx_irq_n), 32'd1);
    check({tag, " pending"}, 32'(fx_pend),  32'h0);
  endtask

  logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    system_reset_n = 1'b0;
    phi1_posedge_i = 1'b0;
    rd_en_i        = 4'b0000;
    data_i         = {8'h44, 8'h33, 8'hA5, 8'h11};  // cards 3..0
    bus_data_i     = 8'h3C;
    irq_n_i        = 4'b1111;
    irq_mask_i     = 4'b0000;
    irq_ack_i      = 4'b0000;

    // Reset state
    tick();
    tick();
    check_reset_fx("reset");
    check("reset rr_cnt", 32'(rr_cnt), 32'd0);

    system_reset_n = 1'b1;
    tick();
    check("idle data=bus", 32'(fx_data), 32'h3C);
    check("idle en",       32'(fx_en),   32'd0);

    // Two cards request together: lowest wins, collision counted
    rd_en_i = 4'b0110;
    tick();
    check("t1 grant", 32'(fx_grant), 32'b0010);
    check("t1 idx",   32'(fx_idx),   32'd1);
    check("t1 data",  32'(fx_data),  32'hA5);
    check("t1 en",    32'(fx_en),    32'd1);
    check("t1 coll",  32'(fx_coll),  32'd1);
    check("t1 cnt",   32'(fx_cnt),   32'd1);

    // Winner drops its request: grant stays locked, no new pulse
    rd_en_i = 4'b0000;
    tick();
    check("t1 hold grant", 32'(fx_grant), 32'b0010);
    check("t1 hold coll",  32'(fx_coll),  32'd0);

    // New bus cycle with card2 alone
    phi1_posedge_i = 1'b1;
    rd_en_i        = 4'b0100;
    tick();
    phi1_posedge_i = 1'b0;
    check("t2 grant",  32'(fx_grant), 32'b0100);
    check("t2 data",   32'(fx_data),  32'h33);
    check("t2 coll0",  32'(fx_coll),  32'd0);

    // Card0 intrudes mid-cycle: grant locked, one pulse only
    rd_en_i = 4'b0001;
    tick();
    check("t2 lock grant", 32'(fx_grant), 32'b0100);
    check("t2 coll",       32'(fx_coll),  32'd1);
    check("t2 cnt",        32'(fx_cnt),   32'd2);
    data_i[2] = 8'h5A;
    tick();
    check("t2 coll once",  32'(fx_coll),  32'd0);
    check("t2 cnt hold",   32'(fx_cnt),   32'd2);
    check("t2 data track", 32'(fx_data),  32'h5A);

    // Bus-cycle boundary hands the bus to card0 with no idle gap
    phi1_posedge_i = 1'b1;
    tick();
    phi1_posedge_i = 1'b0;
    rd_en_i        = 4'b0000;
    check("t2 regrant", 32'(fx_grant), 32'b0001);
    check("t2 reidx",   32'(fx_idx),   32'd0);
    check("t2 redata",  32'(fx_data),  32'h11);

    // IRQ masking, pending and acknowledge
    irq_mask_i = 4'b0101;
    irq_n_i    = 4'b1010;
    tick();
    check("t5 irq_n",   32'(fx_irq_n), 32'd0);
    check("t5 pending", 32'(fx_pend),  32'b0101);
    irq_n_i   = 4'b1111;
    irq_ack_i = 4'b0001;
    tick();
    check("t5 ack pending", 32'(fx_pend),  32'b0100);
    check("t5 ack irq_n",   32'(fx_irq_n), 32'd1);
    irq_n_i   = 4'b1011;
    irq_ack_i = 4'b0100;
    tick();
    irq_ack_i = 4'b0000;
    check("t5 set wins", 32'(fx_pend),  32'b0100);
    check("t5 irq2 low", 32'(fx_irq_n), 32'd0);

    // Reset while granted with pending IRQ
    check("t6 pre en", 32'(fx_en), 32'd1);
    system_reset_n = 1'b0;
    tick();
    check_reset_fx("t6");
    irq_n_i        = 4'b1111;
    irq_mask_i     = 4'b0000;
    system_reset_n = 1'b1;
    tick();

    // Round-robin rotation from pointer 0, 2-bit saturating counter
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        // Empty bus cycle: grant drops, pointer must not move
        phi1_posedge_i = 1'b1;
        rd_en_i        = 4'b0000;
        tick();
        check("t3 empty grant", 32'(rr_grant), 32'h0);
        check("t3 empty en",    32'(rr_en),    32'd0);
      end
      phi1_posedge_i = 1'b1;
      rd_en_i        = 4'b1111;
      tick();
      phi1_posedge_i = 1'b0;
      check($sformatf("t3 idx%0d", k), 32'(rr_idx),   32'(k % 4));
      check($sformatf("t3 oh%0d", k),  32'(rr_grant), 32'(4'b0001 << (k % 4)));
      check($sformatf("t4 cnt%0d", k), 32'(rr_cnt),   32'(exp_cnt[k]));
      check($sformatf("t4 coll%0d", k), 32'(rr_coll), 32'd1);
      tick();
      check($sformatf("t3 held%0d", k), 32'(rr_idx),  32'(k % 4));
      check($sformatf("t4 once%0d", k), 32'(rr_coll), 32'd0);
      rd_en_i = 4'b0000;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
